// File: rtl/mem_access_stage.sv
// Memory stage of the ARM-subset pipeline: issues data loads/stores over a
// req/ack bus, stalls upstream while busy, and registers the MEM/WB values.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_inst,
  input  logic [3:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_we,
  input  logic        ex_byte,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_result,
  output logic [3:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_inst,
  output logic        bus_error
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  logic [CW-1:0] cnt;
  logic [31:0]   c_addr, c_data, c_inst;
  logic [3:0]    c_rd;
  logic          c_rw, c_we, c_byte;
  logic          busy, is_mem, expired;
  logic [7:0]    lane;

  assign busy    = (state == BUSY);
  assign is_mem  = ex_valid & (ex_mem_read | ex_mem_we);
  assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    lane = mem_rdata[7:0];
    case (c_addr[1:0])
      2'd1:    lane = mem_rdata[15:8];
      2'd2:    lane = mem_rdata[23:16];
      2'd3:    lane = mem_rdata[31:24];
      default: lane = mem_rdata[7:0];
    endcase
  end

  // Bus outputs come straight from the captured op and are forced to 0 when idle.
  assign stall     = busy;
  assign mem_req   = busy;
  assign mem_we    = busy & c_we;
  assign mem_addr  = busy ? {c_addr[31:2], 2'b00} : 32'h0;
  assign mem_be    = !busy ? 4'h0 : (c_byte ? (4'b0001 << c_addr[1:0]) : 4'hF);
  assign mem_wdata = !busy ? 32'h0 : (c_byte ? {4{c_data[7:0]}} : c_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      c_addr       <= '0;
      c_data       <= '0;
      c_inst       <= '0;
      c_rd         <= '0;
      c_rw         <= 1'b0;
      c_we         <= 1'b0;
      c_byte       <= 1'b0;
      wb_valid     <= 1'b0;
      wb_result    <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_inst      <= '0;
      bus_error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            c_addr   <= ex_alu_result;
            c_data   <= ex_store_data;
            c_inst   <= ex_inst;
            c_rd     <= ex_rd;
            c_rw     <= ex_reg_write;
            c_we     <= ex_mem_we;
            c_byte   <= ex_byte;
            cnt      <= '0;
            wb_valid <= 1'b0;
            state    <= BUSY;
          end else begin
            wb_valid     <= ex_valid;
            wb_result    <= ex_alu_result;
            wb_rd        <= ex_rd;
            wb_reg_write <= ex_reg_write;
            wb_inst      <= ex_inst;
          end
        end
        BUSY: begin
          // An ack in the expiry cycle still completes the access normally.
          if (mem_ack) begin
            state    <= IDLE;
            wb_valid <= 1'b1;
            wb_rd    <= c_rd;
            wb_inst  <= c_inst;
            if (c_we) begin
              wb_result    <= c_addr;
              wb_reg_write <= 1'b0;
            end else begin
              wb_result    <= c_byte ? {24'h0, lane} : mem_rdata;
              wb_reg_write <= c_rw;
            end
          end else if (expired) begin
            state        <= IDLE;
            bus_error    <= 1'b1;
            wb_valid     <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_result    <= '0;
            wb_rd        <= c_rd;
            wb_inst      <= c_inst;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage with hand-written
// sequences for timeout, ack-at-expiry and reset during an access.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_we, ex_byte;
  logic [31:0] ex_alu_result, ex_store_data, ex_inst;
  logic [3:0]  ex_rd;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, wb_reg_write, bus_error;
  logic [31:0] wb_result, wb_inst;
  logic [3:0]  wb_rd;

  mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_inst(ex_inst), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_we(ex_mem_we),
    .ex_byte(ex_byte), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_result(wb_result), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_inst(wb_inst), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, sdata;
    logic [3:0]  rd;
    logic        rw, mr, mw, bt;
    int          k;
    logic [31:0] rdata, exp_result;
    logic        exp_rw;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int cur   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got %h, expected %h", name, cur, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_mem_read = 0; ex_mem_we = 0; ex_byte = 0; ex_reg_write = 0;
    ex_rd = 0; ex_inst = 0;
    ex_alu_result = 32'hBAD0_BAD0; ex_store_data = 32'hBAD1_BAD1;
  endtask

  // Present one op in IDLE, ack it after v.k busy cycles, then check MEM/WB.
  task automatic apply(input vec_t v, input int idx);
    cur = idx;
    ex_valid = 1; ex_alu_result = v.alu; ex_store_data = v.sdata; ex_rd = v.rd;
    ex_reg_write = v.rw; ex_mem_read = v.mr; ex_mem_we = v.mw; ex_byte = v.bt;
    ex_inst = 32'hE000_0000 + 32'(idx);
    @(posedge clk); #1;
    idle_inputs();
    if (v.mr | v.mw) begin
      chk("bubble", 32'(wb_valid), 0);
      for (int i = 1; i <= v.k; i++) begin
        @(negedge clk);
        chk("stall", 32'(stall), 1);
        chk("mem_req", 32'(mem_req), 1);
        chk("mem_we", 32'(mem_we), 32'(v.mw));
        chk("mem_addr", mem_addr, v.exp_addr);
        chk("mem_be", 32'(mem_be), 32'(v.exp_be));
        chk("mem_wdata", mem_wdata, v.exp_wdata);
        if (i == v.k) begin mem_ack = 1; mem_rdata = v.rdata; end
        @(posedge clk); #1;
        mem_ack = 0; mem_rdata = 0;
      end
    end
    chk("wb_valid", 32'(wb_valid), 1);
    chk("wb_result", wb_result, v.exp_result);
    chk("wb_reg_write", 32'(wb_reg_write), 32'(v.exp_rw));
    chk("wb_rd", 32'(wb_rd), 32'(v.rd));
    chk("wb_inst", wb_inst, 32'hE000_0000 + 32'(idx));
    chk("stall_after", 32'(stall), 0);
    chk("req_after", 32'(mem_req), 0);
    chk("be_after", 32'(mem_be), 0);
    n_vec++;
  endtask

  vec_t vt[8];
  vec_t v;

  initial begin
    //            alu           sdata          rd  rw mr mw bt k   rdata         exp_result    erw be    addr          wdata
    vt[0] = '{32'h0000_1234, 32'h0,         4'd3, 1, 0, 0, 0, 0, 32'h0,        32'h0000_1234, 1, 4'h0, 32'h0,        32'h0};
    vt[1] = '{32'h0000_0106, 32'h0000_0055, 4'd5, 1, 1, 0, 0, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 4'hF, 32'h0000_0104, 32'h0000_0055};
    vt[2] = '{32'h0000_0203, 32'h0000_00A5, 4'd2, 1, 0, 1, 1, 1, 32'h0,        32'h0000_0203, 0, 4'h8, 32'h0000_0200, 32'hA5A5_A5A5};
    vt[3] = '{32'h0000_0001, 32'h1234_5678, 4'd4, 1, 1, 0, 1, 2, 32'h1122_3344, 32'h0000_0033, 1, 4'h2, 32'h0,        32'h7878_7878};
    vt[4] = '{32'h0000_1000, 32'hCAFE_F00D, 4'd6, 0, 0, 1, 0, 1, 32'h0,        32'h0000_1000, 0, 4'hF, 32'h0000_1000, 32'hCAFE_F00D};
    vt[5] = '{32'h0000_0022, 32'h0000_0077, 4'd1, 1, 1, 1, 0, 2, 32'h5555_5555, 32'h0000_0022, 0, 4'hF, 32'h0000_0020, 32'h0000_0077};
    vt[6] = '{32'hFFFF_FFFF, 32'h0,         4'd7, 0, 0, 0, 0, 0, 32'h0,        32'hFFFF_FFFF, 0, 4'h0, 32'h0,        32'h0};
    vt[7] = '{32'h0000_0307, 32'h0000_00C3, 4'd9, 1, 1, 0, 1, 4, 32'h9A00_0000, 32'h0000_009A, 1, 4'h8, 32'h0000_0304, 32'hC3C3_C3C3};

    idle_inputs(); mem_ack = 0; mem_rdata = 0; reset = 1;
    @(posedge clk); @(posedge clk); #1;
    cur = -1;
    chk("rst_wb_valid", 32'(wb_valid), 0); chk("rst_wb_result", wb_result, 0);
    chk("rst_wb_rw", 32'(wb_reg_write), 0); chk("rst_bus_error", 32'(bus_error), 0);
    chk("rst_stall", 32'(stall), 0); chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
    n_vec++;
    reset = 0;

    for (int i = 0; i < 8; i++) apply(vt[i], i);

    // ex_valid=0 with a load flag is not a memory op.
    cur = 100;
    ex_valid = 0; ex_mem_read = 1; ex_reg_write = 1; ex_alu_result = 32'h40;
    @(posedge clk); #1;
    chk("inv_wb_valid", 32'(wb_valid), 0); chk("inv_stall", 32'(stall), 0);
    chk("inv_mem_req", 32'(mem_req), 0);
    idle_inputs(); n_vec++;

    // Timeout: load never acked aborts at accept+16; ack outside BUSY is ignored.
    cur = 101;
    ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 4'd8; ex_alu_result = 32'h80;
    @(posedge clk); #1;
    idle_inputs();
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) begin
        chk("to_pre_err", 32'(bus_error), 0); chk("to_pre_stall", 32'(stall), 1);
        chk("to_pre_req", 32'(mem_req), 1);
      end
      @(posedge clk); #1;
    end
    chk("to_bus_error", 32'(bus_error), 1); chk("to_wb_valid", 32'(wb_valid), 1);
    chk("to_wb_rw", 32'(wb_reg_write), 0); chk("to_wb_result", wb_result, 0);
    chk("to_mem_req", 32'(mem_req), 0); chk("to_stall", 32'(stall), 0);
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 0; mem_rdata = 0;
    chk("stray_ack_valid", 32'(wb_valid), 0);
    n_vec++;
    apply(vt[0], 102);
    chk("err_sticky", 32'(bus_error), 1);

    reset = 1; @(posedge clk); #1; reset = 0;
    cur = 103;
    chk("err_cleared", 32'(bus_error), 0);

    // Ack at the last counted cycle wins over expiry.
    v = '{32'h0000_0100, 32'h0, 4'd10, 1, 1, 0, 0, 16, 32'h0BAD_F00D, 32'h0BAD_F00D, 1, 4'hF, 32'h0000_0100, 32'h0};
    apply(v, 104);
    chk("ack_edge_no_err", 32'(bus_error), 0);

    // Reset during BUSY discards the op.
    cur = 105;
    ex_valid = 1; ex_mem_we = 1; ex_alu_result = 32'h0000_0400; ex_store_data = 32'h1;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    chk("pre_rst_req", 32'(mem_req), 1);
    reset = 1; @(posedge clk); #1; reset = 0;
    chk("mid_rst_req", 32'(mem_req), 0); chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_we", 32'(mem_we), 0); chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wb_valid", 32'(wb_valid), 0);
    mem_ack = 1; @(posedge clk); #1; mem_ack = 0;
    chk("mid_rst_no_wb", 32'(wb_valid), 0);
    n_vec++;
    apply(vt[6], 106);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
